// File: rtl/lsu_unit_if.sv
// Core-side and data-memory-side signal bundle for the load/store unit.
interface lsu_unit_if;
    logic        i_lsu_valid;
    logic        i_lsu_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_mem_req;
    logic        i_mem_ack;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_stall;
    logic [1:0]  o_err;

    modport slave (
        input  i_lsu_valid, i_lsu_we, i_funct3, i_addr, i_st_data,
        input  i_mem_ack, i_mem_rdata,
        output o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        output o_ld_data, o_done, o_stall, o_err
    );

    modport master (
        output i_lsu_valid, i_lsu_we, i_funct3, i_addr, i_st_data,
        output i_mem_ack, i_mem_rdata,
        input  o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        input  o_ld_data, o_done, o_stall, o_err
    );
endinterface

// File: rtl/lsu_unit.sv
// RV32I load/store unit: req/ack memory access with alignment, size
// and bus-timeout checking, returning extended load data.
module lsu_unit #(
    parameter int TIMEOUT = 16
) (
    input logic       i_clk,
    input logic       i_rst_n,
    lsu_unit_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    off;
    logic [2:0]    f3;

    logic          illegal;
    logic          misalign;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   shifted;
    logic [31:0]   ld_n;

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        unique case (bus.i_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b100, 3'b101:         illegal = bus.i_lsu_we;
            default:                illegal = 1'b0;
        endcase
        unique case (bus.i_funct3[1:0])
            2'b01:   misalign = bus.i_addr[0];
            2'b10:   misalign = |bus.i_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = bus.i_st_data;
        unique case (bus.i_funct3[1:0])
            2'b00: begin
                if (bus.i_lsu_we) be_n = 4'b0001 << bus.i_addr[1:0];
                wdata_n = {4{bus.i_st_data[7:0]}};
            end
            2'b01: begin
                if (bus.i_lsu_we) be_n = 4'b0011 << {bus.i_addr[1], 1'b0};
                wdata_n = {2{bus.i_st_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = bus.i_st_data;
            end
        endcase
    end

    always_comb begin
        shifted = bus.i_mem_rdata >> {off, 3'b000};
        unique case (f3)
            3'b000:  ld_n = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_n = {24'd0, shifted[7:0]};
            3'b001:  ld_n = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_n = {16'd0, shifted[15:0]};
            default: ld_n = shifted;
        endcase
    end

    assign bus.o_stall = bus.i_lsu_valid && (state != RESP);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            off             <= '0;
            f3              <= '0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_be    <= '0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_ld_data   <= '0;
            bus.o_done      <= 1'b0;
            bus.o_err       <= '0;
        end else begin
            bus.o_done <= 1'b0;
            unique case (state)
                IDLE: if (bus.i_lsu_valid) begin
                    bus.o_mem_addr  <= {bus.i_addr[31:2], 2'b00};
                    bus.o_mem_we    <= bus.i_lsu_we;
                    bus.o_mem_be    <= be_n;
                    bus.o_mem_wdata <= wdata_n;
                    off             <= bus.i_addr[1:0];
                    f3              <= bus.i_funct3;
                    cnt             <= '0;
                    // Rejected accesses never reach the bus
                    if (illegal || misalign) begin
                        state         <= RESP;
                        bus.o_done    <= 1'b1;
                        bus.o_err     <= illegal ? 2'b11 : 2'b01;
                        bus.o_ld_data <= '0;
                    end else begin
                        state         <= REQ;
                        bus.o_mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.i_mem_ack) begin
                        state         <= RESP;
                        bus.o_mem_req <= 1'b0;
                        bus.o_done    <= 1'b1;
                        bus.o_err     <= 2'b00;
                        bus.o_ld_data <= bus.o_mem_we ? '0 : ld_n;
                    end else if (cnt == TMAX) begin
                        state         <= RESP;
                        bus.o_mem_req <= 1'b0;
                        bus.o_done    <= 1'b1;
                        bus.o_err     <= 2'b10;
                        bus.o_ld_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
// Randomized scoreboard bench for lsu_unit with a behavioural
// memory responder and an arithmetic reference model.
module tb_lsu_unit;
    logic clk = 1'b0;
    logic rst_n;

    lsu_unit_if bus ();

    lsu_unit #(.TIMEOUT(16)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  err;
        int          nreq;
        int          lat;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } plan_t;

    exp_t  sb[$];
    plan_t plan[$];
    int    checks = 0;
    int    passes = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(bit we, bit [2:0] f3, bit [31:0] a,
                                   bit [31:0] st, bit [31:0] rd, int delay);
        exp_t   e;
        int     size;
        int     off;
        longint v;
        bit     ill;
        bit     mis;
        size = 1 << f3[1:0];
        off  = int'(a % 4);
        ill  = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4);
        mis  = !ill && (a % size != 0);
        e.err  = ill ? 2'd3 : mis ? 2'd1 : (delay >= 16) ? 2'd2 : 2'd0;
        e.nreq = (ill || mis) ? 0 : (delay >= 16) ? 16 : delay + 1;
        e.lat  = (ill || mis) ? 1 : (delay >= 16) ? 17 : delay + 2;
        e.maddr = a - 32'(off);
        e.we    = we;
        e.be    = we ? 4'(((1 << size) - 1) << off) : 4'hf;
        for (int i = 0; i < 4; i++)
            e.wdata[8*i +: 8] = st[8*(i % size) +: 8];
        e.ld = '0;
        if (e.err == 0 && !we) begin
            v = longint'(rd) >> (8 * off);
            v = v % (longint'(1) << (8 * size));
            if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            e.ld = 32'(v);
        end
        return e;
    endfunction

    // Memory responder: acks after the planned number of request cycles
    int   rcyc = 0;
    logic preq = 1'b0;
    always @(negedge clk) begin
        if (bus.o_mem_req && plan.size() > 0) begin
            bus.i_mem_ack   = (rcyc == plan[0].delay);
            bus.i_mem_rdata = bus.i_mem_ack ? plan[0].rdata : $urandom;
            rcyc++;
        end else begin
            bus.i_mem_ack   = 1'b0;
            bus.i_mem_rdata = $urandom;
        end
        if (!bus.o_mem_req && preq) begin
            if (plan.size() > 0) void'(plan.pop_front());
            rcyc = 0;
        end
        preq = bus.o_mem_req;
    end

    // Monitor: bus fields during requests, results on completion
    int   rcnt = 0;
    exp_t m;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = 0;
        end else begin
            if (bus.o_mem_req) begin
                if (sb.size() > 0) begin
                    chk("mem_addr", bus.o_mem_addr, sb[0].maddr);
                    chk("mem_we", 32'(bus.o_mem_we), 32'(sb[0].we));
                    chk("mem_be", 32'(bus.o_mem_be), 32'(sb[0].be));
                    if (sb[0].we)
                        chk("mem_wdata", bus.o_mem_wdata, sb[0].wdata);
                end
                rcnt++;
            end
            if (bus.o_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m = sb.pop_front();
                    chk("ld_data", bus.o_ld_data, m.ld);
                    chk("err", 32'(bus.o_err), 32'(m.err));
                    chk("req_cycles", rcnt, m.nreq);
                end
                rcnt = 0;
            end
        end
    end

    task automatic issue(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] st,
                         bit [31:0] rd, int delay, bit flush);
        exp_t e;
        bit   done;
        e = model(we, f3, a, st, rd, delay);
        sb.push_back(e);
        if (e.nreq > 0) plan.push_back('{delay, rd});
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_we    = we;
        bus.i_funct3    = f3;
        bus.i_addr      = a;
        bus.i_st_data   = st;
        done = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.i_lsu_valid)
                chk("stall", 32'(bus.o_stall), 32'(!bus.o_done));
            if (bus.o_done) begin
                chk("latency", k, e.lat);
                done = 1'b1;
                break;
            end
            if (flush && k == 1) bus.i_lsu_valid = 1'b0;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        bus.i_lsu_valid = 1'b0;
        bus.i_lsu_we    = 1'($urandom);
        bus.i_funct3    = 3'($urandom);
        bus.i_addr      = $urandom;
        bus.i_st_data   = $urandom;
        repeat ($urandom_range(1, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_req"}, 32'(bus.o_mem_req), 32'd0);
        chk({tag, "_we"}, 32'(bus.o_mem_we), 32'd0);
        chk({tag, "_be"}, 32'(bus.o_mem_be), 32'd0);
        chk({tag, "_addr"}, bus.o_mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.o_mem_wdata, 32'd0);
        chk({tag, "_ld"}, bus.o_ld_data, 32'd0);
        chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.o_err), 32'd0);
    endtask

    initial begin
        int d;
        rst_n           = 1'b0;
        bus.i_lsu_valid = 1'b0;
        bus.i_lsu_we    = 1'b0;
        bus.i_funct3    = 3'd0;
        bus.i_addr      = 32'd0;
        bus.i_st_data   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
        issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b100, 32'h100, 32'h5, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b011, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'h104, 32'h0, 32'h11111111, 99, 1'b0);
        issue(1'b0, 3'b010, 32'h108, 32'h0, 32'h55AA55AA, 15, 1'b0);
        issue(1'b0, 3'b001, 32'h10A, 32'h0, 32'hF00D8001, 2, 1'b1);

        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, 9);
            if (d < 8) d = $urandom_range(0, 3);
            else if (d == 8) d = 99;
            else d = $urandom_range(4, 15);
            issue(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                  d, ($urandom_range(0, 7) == 0));
        end

        // Reset in the third request cycle abandons the access
        sb.push_back(model(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 99));
        plan.push_back('{99, 32'h0});
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_we    = 1'b0;
        bus.i_funct3    = 3'b010;
        bus.i_addr      = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_req", 32'(bus.o_mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        sb.delete();
        bus.i_lsu_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU in the RV32I single-cycle core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a request/acknowledge transaction to data memory and returns sign- or zero-extended load data for writeback.
- Stalls the PC until the access completes; flags misaligned, illegal-size and timed-out accesses.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for i_mem_ack before bus error; counter width = $clog2(TIMEOUT+1).

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_lsu_valid  input  1  current instruction is a load/store; held high by core while o_stall=1.
- i_lsu_we  input  1  1=store, 0=load.
- i_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  input  32  effective address (ALU result).
- i_st_data  input  32  rs2 data.
- o_mem_req  output  1  memory request.
- i_mem_ack  input  1  memory completes the request this cycle.
- o_mem_addr  output  32  word address, {addr[31:2],2'b00}.
- o_mem_we  output  1  write enable.
- o_mem_be  output  4  byte enables.
- o_mem_wdata  output  32  lane-replicated store data.
- i_mem_rdata  input  32  read word, valid when i_mem_ack=1.
- o_ld_data  output  32  extended load result.
- o_done  output  1  one-cycle completion pulse.
- o_stall  output  1  hold PC/instruction.
- o_err  output  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal size; valid when o_done=1.

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Reset (i_rst_n=0 at clock edge): state=IDLE, timeout counter=0, all registered outputs 0 (o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_ld_data, o_done, o_err). A reset mid-transaction drops o_mem_req at that edge; the transaction is abandoned.
- Request capture: in IDLE with i_lsu_valid=1, capture addr, we, funct3 and st_data into registers. The memory outputs are driven from these registers only.
- Illegal size: funct3 in {011,110,111}, or a store with funct3[2]=1. Go IDLE->RESP with o_err=11; no memory request is issued.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00. Go IDLE->RESP with o_err=01; no request. Illegal size takes priority over misaligned.
- Normal access: IDLE->REQ. In REQ, o_mem_req=1 and the memory outputs are stable until ack.
- On i_mem_ack in REQ: go to RESP and register o_ld_data (loads) or set it to 0 (stores). Set o_err=00.
- Timeout: counter increments each REQ cycle without ack. When counter reaches TIMEOUT-1 with no ack, go to RESP with o_err=10 and o_ld_data=0. If ack arrives in that same cycle, ack wins.
- RESP: o_done=1 for exactly one cycle, then IDLE. o_err and o_ld_data hold until the next capture.
- o_stall is combinational: i_lsu_valid && state!=RESP.
- Minimum latency: valid at cycle 0, req at cycle 1, ack at cycle 1, done at cycle 2.
- Flush: if i_lsu_valid drops during REQ, o_mem_req stays high until ack or timeout (protocol rule: req never withdrawn before ack). Then RESP occurs as normal, and the core ignores it.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
  - Loads drive o_mem_be=4'b1111.
- Store data: B {4{st[7:0]}}, H {2{st[15:0]}}, W unchanged.
- Load extract:
  - Shift rdata right by {addr[1:0],3'b000}.
  - B: sign-extend bit 7. BU: zero-extend bits 7:0.
  - H: sign-extend bit 15. HU: zero-extend bits 15:0.
  - W: unchanged.
- Back-to-back accesses: a new capture is possible in the IDLE cycle immediately after RESP.

Test Plan:
- LW addr=0x100, ack next cycle, rdata=0xDEADBEEF -> o_mem_addr=0x100, be=1111, o_done at cycle 2, o_ld_data=0xDEADBEEF, o_err=00.
- LB addr=0x103, rdata=0x80123456 -> be=1111, o_ld_data=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr=0x202, st_data=0x1234ABCD -> o_mem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1, o_ld_data=0.
- LW addr=0x101 -> no o_mem_req ever, o_done at cycle 1, o_err=01. Store with funct3=100 -> o_err=11.
- TIMEOUT=16, ack never asserted -> o_mem_req high 16 cycles, o_done with o_err=10. Repeat with ack on the 16th cycle -> o_err=00.
- Assert i_rst_n=0 in the 3rd REQ cycle -> next edge: o_mem_req=0, state IDLE, all outputs 0. A following LW completes normally.
